// File: rtl/dec2exe_shift_fifo.sv
// Two-entry decode-to-execute FIFO carrying shift ops (data, amount, cmd, tag).
// Push side: PUSH_VALID_SD/PUSH_READY_SD, OP1_SD, OP2_SD, CMD_SD, DEST_SD.
// Pop side: POP_VALID_SE/POP_READY_SE, DIN_SE, SHIFT_VAL_SE, CMD_SE, DEST_SE.
// COUNT_SE reports occupancy; FLUSH_SE kills every entry.
// Optional macro SHIFT_FIFO_BYPASS_EN: an empty FIFO forwards a push straight
// to the pop side in the same cycle.
module dec2exe_shift_fifo (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        FLUSH_SE,
  input  logic        PUSH_VALID_SD,
  output logic        PUSH_READY_SD,
  input  logic [31:0] OP1_SD,
  input  logic [31:0] OP2_SD,
  input  logic [1:0]  CMD_SD,
  input  logic [5:0]  DEST_SD,
  output logic        POP_VALID_SE,
  input  logic        POP_READY_SE,
  output logic [31:0] DIN_SE,
  output logic [4:0]  SHIFT_VAL_SE,
  output logic [1:0]  CMD_SE,
  output logic [5:0]  DEST_SE,
  output logic [1:0]  COUNT_SE
);

  typedef struct packed {
    logic [31:0] op1;
    logic [4:0]  sh;
    logic [1:0]  cmd;
    logic [5:0]  dest;
  } ent_t;

  ent_t       mem_q [2];
  ent_t       push_ent;
  ent_t       head;
  logic [1:0] count_q, count_d;
  logic       rd_ptr_q, rd_ptr_d;
  logic       wr_ptr_q, wr_ptr_d;
  logic       push_fire;
  logic       byp_take;
  logic       wr_en, rd_en;
  logic       unused_op2;

  // Only the low five bits of the amount matter to a 32-bit shifter.
  assign unused_op2 = ^OP2_SD[31:5];

  assign push_ent = '{
    op1:  OP1_SD,
    sh:   OP2_SD[4:0],
    cmd:  CMD_SD,
    dest: DEST_SD
  };

  // Ready is purely a function of stored occupancy, so a full FIFO
  // refuses a push even when the head drains in the same cycle.
  assign PUSH_READY_SD = (count_q != 2'd2);
  assign push_fire     = PUSH_VALID_SD & PUSH_READY_SD & ~FLUSH_SE;

`ifdef SHIFT_FIFO_BYPASS_EN
  logic byp;
  assign byp = (count_q == 2'd0) & PUSH_VALID_SD & ~FLUSH_SE & ~RESET;
  assign POP_VALID_SE = (count_q != 2'd0) | byp;
  assign head         = byp ? push_ent : mem_q[rd_ptr_q];
  // A forwarded op that execute takes right away never lands in storage.
  assign byp_take     = byp & POP_READY_SE;
`else
  assign POP_VALID_SE = (count_q != 2'd0);
  assign head         = mem_q[rd_ptr_q];
  assign byp_take     = 1'b0;
`endif

  assign DIN_SE       = head.op1;
  assign SHIFT_VAL_SE = head.sh;
  assign CMD_SE       = head.cmd;
  assign DEST_SE      = head.dest;
  assign COUNT_SE     = count_q;

  assign wr_en = push_fire & ~byp_take;
  assign rd_en = POP_READY_SE & (count_q != 2'd0) & ~FLUSH_SE;

  always_comb begin
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (wr_en) wr_ptr_d = ~wr_ptr_q;
    if (rd_en) rd_ptr_d = ~rd_ptr_q;
    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
    if (FLUSH_SE) begin
      count_d  = 2'd0;
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      count_q  <= 2'd0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
    end else begin
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

  // Payload storage is left unreset; valid tracking lives in count_q.
  always_ff @(posedge CLK) begin
    if (wr_en & ~RESET) mem_q[wr_ptr_q] <= push_ent;
  end

endmodule

// File: tb/tb_dec2exe_shift_fifo.sv
// Scoreboard bench for dec2exe_shift_fifo.
// Expected entries are queued on accepted pushes and compared at the head.
module tb_dec2exe_shift_fifo;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        FLUSH_SE;
  logic        PUSH_VALID_SD;
  logic        PUSH_READY_SD;
  logic [31:0] OP1_SD;
  logic [31:0] OP2_SD;
  logic [1:0]  CMD_SD;
  logic [5:0]  DEST_SD;
  logic        POP_VALID_SE;
  logic        POP_READY_SE;
  logic [31:0] DIN_SE;
  logic [4:0]  SHIFT_VAL_SE;
  logic [1:0]  CMD_SE;
  logic [5:0]  DEST_SE;
  logic [1:0]  COUNT_SE;

  typedef struct packed {
    logic [31:0] d;
    logic [4:0]  s;
    logic [1:0]  c;
    logic [5:0]  t;
  } ent_t;

  ent_t q[$];
  int   checks = 0;
  int   errors = 0;

  dec2exe_shift_fifo dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .FLUSH_SE     (FLUSH_SE),
    .PUSH_VALID_SD(PUSH_VALID_SD),
    .PUSH_READY_SD(PUSH_READY_SD),
    .OP1_SD       (OP1_SD),
    .OP2_SD       (OP2_SD),
    .CMD_SD       (CMD_SD),
    .DEST_SD      (DEST_SD),
    .POP_VALID_SE (POP_VALID_SE),
    .POP_READY_SE (POP_READY_SE),
    .DIN_SE       (DIN_SE),
    .SHIFT_VAL_SE (SHIFT_VAL_SE),
    .CMD_SE       (CMD_SE),
    .DEST_SE      (DEST_SE),
    .COUNT_SE     (COUNT_SE)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", tag, obs, exp);
    end
  endtask

  // One cycle: drive, check combinational outputs, clock, update model.
  task automatic step(input logic pv, input logic [31:0] op1,
                      input logic [31:0] op2, input logic [1:0] cmd,
                      input logic [5:0] dest, input logic pr,
                      input logic fl, input logic rst);
    ent_t in_e;
    ent_t e;
    logic byp;
    logic ev;
    logic push_ok;
    logic pop_ok;
    PUSH_VALID_SD = pv;
    OP1_SD        = op1;
    OP2_SD        = op2;
    CMD_SD        = cmd;
    DEST_SD       = dest;
    POP_READY_SE  = pr;
    FLUSH_SE      = fl;
    RESET         = rst;
    in_e = '{d: op1, s: op2[4:0], c: cmd, t: dest};
    byp = 1'b0;
`ifdef SHIFT_FIFO_BYPASS_EN
    byp = (q.size() == 0) && pv && !fl && !rst;
`endif
    ev = (q.size() != 0) || byp;
    #2;
    chk("count", 32'(COUNT_SE), 32'(q.size()));
    chk("push_ready", 32'(PUSH_READY_SD), 32'(q.size() != 2));
    chk("pop_valid", 32'(POP_VALID_SE), 32'(ev));
    if (ev) begin
      e = byp ? in_e : q[0];
      chk("din", DIN_SE, e.d);
      chk("shift_val", 32'(SHIFT_VAL_SE), 32'(e.s));
      chk("cmd", 32'(CMD_SE), 32'(e.c));
      chk("dest", 32'(DEST_SE), 32'(e.t));
    end
    @(posedge CLK);
    if (rst || fl) begin
      q.delete();
    end else if (!(byp && pr)) begin
      push_ok = pv && (q.size() != 2);
      pop_ok  = pr && (q.size() != 0);
      if (pop_ok) void'(q.pop_front());
      if (push_ok) q.push_back(in_e);
    end
    #1;
  endtask

  task automatic idle(input logic pr);
    step(1'b0, 32'h0, 32'h0, 2'b00, 6'd0, pr, 1'b0, 1'b0);
  endtask

  task automatic push(input logic [31:0] d, input logic pr);
    step(1'b1, d, {27'h5a5a5a5, d[4:0]}, d[1:0], d[5:0], pr, 1'b0, 1'b0);
  endtask

  initial begin
    RESET = 1'b1; FLUSH_SE = 1'b0; PUSH_VALID_SD = 1'b0;
    POP_READY_SE = 1'b0; OP1_SD = '0; OP2_SD = '0;
    CMD_SD = '0; DEST_SD = '0;
    repeat (2) @(posedge CLK);
    #1;
    RESET = 1'b0;
    q.delete();

    idle(1'b0);
    idle(1'b1);

    step(1'b1, 32'h8000_0000, 32'h0000_0024, 2'b10, 6'd5, 1'b0, 1'b0, 1'b0);
    idle(1'b0);
    idle(1'b1);

    push(32'h1, 1'b0);
    push(32'h2, 1'b0);
    push(32'h3, 1'b0);
    push(32'h3, 1'b1);
    idle(1'b1);
    idle(1'b1);
    idle(1'b1);

    push(32'h10, 1'b0);
    for (int i = 0; i < 4; i++)
      push(32'h20 + 32'(i), 1'b1);
    idle(1'b1);

    step(1'b1, 32'hfff0_000f, 32'hffff_ffff, 2'b11, 6'd63,
         1'b0, 1'b0, 1'b0);
    idle(1'b1);

    push(32'h41, 1'b0);
    push(32'h42, 1'b0);
    step(1'b1, 32'h43, 32'h3, 2'b01, 6'd3, 1'b0, 1'b1, 1'b0);
    idle(1'b0);

    push(32'h51, 1'b0);
    push(32'h52, 1'b0);
    step(1'b1, 32'h53, 32'h3, 2'b01, 6'd3, 1'b1, 1'b1, 1'b1);
    idle(1'b0);
    push(32'h55, 1'b0);
    idle(1'b1);
    idle(1'b0);

    step(1'b1, 32'hdead_beef, 32'h1f, 2'b00, 6'd9, 1'b1, 1'b0, 1'b0);
    idle(1'b1);
    idle(1'b0);

    for (int i = 0; i < 300; i++) begin
      step(1'($urandom_range(0, 1)), $urandom, $urandom,
           2'($urandom_range(0, 3)), 6'($urandom_range(0, 63)),
           1'($urandom_range(0, 1)),
           ($urandom_range(0, 15) == 0), ($urandom_range(0, 31) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
